// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for uart_tx_arbiter: state encoding, default framing bytes, parameter range checks.
// UART_TX_ARB_CHECKSUM_EN adds the CSUM state to the encoding.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAD   = 3'd1,
        ST_P_REQ  = 3'd2,
        ST_P_WAIT = 3'd3,
        ST_TAIL   = 3'd4,
        ST_DONE   = 3'd5
`ifdef UART_TX_ARB_CHECKSUM_EN
        ,
        ST_CSUM   = 3'd6
`endif
    } state_e;

    localparam logic [7:0] DEF_HEAD_BYTE = 8'h0a;
    localparam logic [7:0] DEF_TAIL_BYTE = 8'h0a;

    function automatic bit max_len_ok(input int n);
        return (n >= 1) && (n <= 255);
    endfunction

    function automatic bit nreq_ok(input int n);
        return (n >= 2) && (n <= 8);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr (mod NREQ).
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx,
    output logic            any
);

    logic [3:0] idx;
    logic       hit;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        hit     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            hit = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                if (idx == 4'(j)) begin
                    hit = req[j];
                end
            end
            if (hit) begin
                gnt_idx = idx[2:0];
                any     = 1'b1;
            end
        end
    end

    assign gnt = any ? (NREQ'(1'b1) << gnt_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_byte_tx among NREQ byte streams, HEAD/payload/TAIL frames.
// Define UART_TX_ARB_CHECKSUM_EN to insert an XOR checksum byte before TAIL.
//
// state   | meaning
// IDLE    | no owner; grant next requester in round-robin order
// HEAD    | HEAD_BYTE sent, waiting Tx_Done
// P_REQ   | req_ready to owner, waiting for its next byte
// P_WAIT  | payload byte sent, waiting Tx_Done
// CSUM    | checksum byte sent, waiting Tx_Done (checksum builds only)
// TAIL    | TAIL_BYTE sent, waiting Tx_Done
// DONE    | advance round-robin pointer past owner
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int         NREQ      = 4,
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] HEAD_BYTE = DEF_HEAD_BYTE,
    parameter logic [7:0] TAIL_BYTE = DEF_TAIL_BYTE
) (
    input  logic                pixelclk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                send_en,
    output logic [7:0]          Data_Byte,
    input  logic                Tx_Done,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic                trunc_err
);

    if (!max_len_ok(MAX_LEN) || !nreq_ok(NREQ)) begin : g_bad_params
        $error("uart_tx_arbiter: NREQ must be 2..8 and MAX_LEN 1..255");
    end

    state_e          state_q, state_d;
    logic [2:0]      grant_q, grant_d, ptr_q, ptr_d;
    logic [NREQ-1:0] grant_oh_q, grant_oh_d;
    logic [7:0]      cnt_q, cnt_d, data_q, data_d;
    logic            last_q, last_d, send_q, send_d, trunc_q, trunc_d;
    logic [NREQ-1:0] arb_gnt;
    logic [2:0]      arb_idx;
    logic            arb_any;
    logic            own_valid, own_last;
    logic [7:0]      own_data;
    logic            tx_ack, at_max, pay_end;
`ifdef UART_TX_ARB_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
    localparam state_e ST_POST_PAY = ST_CSUM;
`else
    localparam state_e ST_POST_PAY = ST_TAIL;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == 3'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    // A Tx_Done coinciding with our own start pulse cannot belong to that byte.
    assign tx_ack  = Tx_Done & ~send_q;
    assign at_max  = (cnt_q == 8'(MAX_LEN));
    assign pay_end = tx_ack & (last_q | at_max);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any)   state_d = ST_HEAD;
            ST_HEAD:   if (tx_ack)    state_d = ST_P_REQ;
            ST_P_REQ:  if (own_valid) state_d = ST_P_WAIT;
            ST_P_WAIT: if (tx_ack)    state_d = pay_end ? ST_POST_PAY : ST_P_REQ;
`ifdef UART_TX_ARB_CHECKSUM_EN
            ST_CSUM:   if (tx_ack)    state_d = ST_TAIL;
`endif
            ST_TAIL:   if (tx_ack)    state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        data_d     = data_q;
        send_d     = 1'b0;
        trunc_d    = 1'b0;
`ifdef UART_TX_ARB_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_idx;
                    grant_oh_d = arb_gnt;
                    cnt_d      = '0;
                    data_d     = HEAD_BYTE;
                    send_d     = 1'b1;
`ifdef UART_TX_ARB_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_P_REQ: begin
                if (own_valid) begin
                    data_d = own_data;
                    last_d = own_last;
                    cnt_d  = cnt_q + 8'd1;
                    send_d = 1'b1;
`ifdef UART_TX_ARB_CHECKSUM_EN
                    csum_d = csum_q ^ own_data;
`endif
                end
            end
            ST_P_WAIT: begin
                if (pay_end) begin
                    trunc_d = ~last_q;
                    send_d  = 1'b1;
`ifdef UART_TX_ARB_CHECKSUM_EN
                    data_d  = csum_q;
`else
                    data_d  = TAIL_BYTE;
`endif
                end
            end
`ifdef UART_TX_ARB_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ack) begin
                    data_d = TAIL_BYTE;
                    send_d = 1'b1;
                end
            end
`endif
            ST_DONE: ptr_d = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
            default: ;
        endcase
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            grant_q    <= '0;
            grant_oh_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            data_q     <= '0;
            send_q     <= 1'b0;
            trunc_q    <= 1'b0;
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            data_q     <= data_d;
            send_q     <= send_d;
            trunc_q    <= trunc_d;
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_P_REQ) ? grant_oh_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign send_en   = send_q;
    assign Data_Byte = data_q;
    assign grant_id  = grant_q;
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 3-cycle UART model and queue-driven requesters.
// Expected frames follow UART_TX_ARB_CHECKSUM_EN the same way the design does.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int MAX_LEN = 4;
`ifdef UART_TX_ARB_CHECKSUM_EN
    localparam int FLEN1 = 4;
`else
    localparam int FLEN1 = 3;
`endif

    logic              pixelclk  = 1'b0;
    logic              reset_n   = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_last  = '0;
    logic              Tx_Done   = 1'b0;
    logic [NREQ-1:0]   req_ready;
    logic              send_en;
    logic [7:0]        Data_Byte;
    logic              busy;
    logic [2:0]        grant_id;
    logic              trunc_err;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .send_en   (send_en),
        .Data_Byte (Data_Byte),
        .Tx_Done   (Tx_Done),
        .busy      (busy),
        .grant_id  (grant_id),
        .trunc_err (trunc_err)
    );

    always #5 pixelclk = ~pixelclk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [8:0] rq [NREQ][$];
    logic [7:0] tx_log[$], exp_q[$], pl_q[$];
    int send_cyc[$], done_cyc[$], grant_log[$];
    int tx_cnt = 0, proto_viol = 0, ready_viol = 0, trunc_cnt = 0;
    int valid_rise_cyc = 0, busy_fall_cyc = 0;
    logic [7:0] cur_byte = '0;
    logic [NREQ-1:0] hs_prev = '0, prev_valid = '0;
    logic busy_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART model, monitors and requester drivers, all on the falling edge.
    always @(negedge pixelclk) begin
        cyc++;
        if (!reset_n) begin
            tx_cnt    = 0;
            Tx_Done   = 1'b0;
            hs_prev   = '0;
            req_valid = '0;
            busy_prev = 1'b0;
        end else begin
            if (tx_cnt > 0 && Data_Byte !== cur_byte) proto_viol++;
            Tx_Done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    Tx_Done = 1'b1;
                    done_cyc.push_back(cyc);
                end
            end
            if (send_en) begin
                if (tx_cnt > 0) proto_viol++;
                tx_log.push_back(Data_Byte);
                send_cyc.push_back(cyc);
                cur_byte = Data_Byte;
                tx_cnt   = 3;
            end
            if (trunc_err) trunc_cnt++;
            if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
            if (!busy && busy_prev) busy_fall_cyc = cyc;
            busy_prev = busy;
            if (req_ready != '0 && req_ready != (NREQ'(1'b1) << grant_id)) ready_viol++;
            if (!busy && req_ready != '0) ready_viol++;
            for (int i = 0; i < NREQ; i++) begin
                if (hs_prev[i]) void'(rq[i].pop_front());
            end
            prev_valid = req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0][7:0];
                    req_last[i]         = rq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = '0;
                    req_last[i]         = 1'b0;
                end
            end
            if (prev_valid == '0 && req_valid != '0) valid_rise_cyc = cyc;
            hs_prev = req_valid & req_ready;
        end
    end

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic last);
        rq[r].push_back({last, b});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        tx_log.delete(); exp_q.delete(); send_cyc.delete(); done_cyc.delete(); grant_log.delete();
    endtask

    task automatic exp_frame();
        exp_q.push_back(8'h0a);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
`ifdef UART_TX_ARB_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = '0;
            foreach (pl_q[i]) cs ^= pl_q[i];
            exp_q.push_back(cs);
        end
`endif
        exp_q.push_back(8'h0a);
        pl_q.delete();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < tx_log.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int q, n;
        q = 0; n = 0;
        while (q < 4 && n < budget) begin
            tick();
            n++;
            if (all_empty() && !busy && tx_cnt == 0 && req_valid == '0) q++;
            else q = 0;
        end
        chk({tag, "_done"}, 32'(q), 32'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_send_en"},   32'(send_en),   32'd0);
        chk({tag, "_data_byte"}, 32'(Data_Byte), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_grant_id"},  32'(grant_id),  32'd0);
        chk({tag, "_trunc_err"}, 32'(trunc_err), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n, n0, bad;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // one 2-byte frame from req0
        clear_logs();
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b1);
        wait_quiet("s1", 400);
        pl_q.push_back(8'h31); pl_q.push_back(8'h32); exp_frame();
        check_log("s1");
        chk("s1_head_lat",  32'(send_cyc[0] - valid_rise_cyc), 32'd1);
        chk("s1_pay_gap",   32'(send_cyc[1] - done_cyc[0]), 32'd2);
        chk("s1_fixed_gap", 32'(send_cyc[3] - done_cyc[2]), 32'd1);
        chk("s1_busy_drop", 32'(busy_fall_cyc - done_cyc[done_cyc.size()-1]), 32'd2);
        chk("s1_grant",     32'(grant_log[0]), 32'd0);

        // round robin from pointer 0
        do_reset();
        clear_logs();
        push(0, 8'haa, 1'b1);
        push(0, 8'hdd, 1'b1);
        push(1, 8'hbb, 1'b1);
        push(2, 8'hcc, 1'b1);
        wait_quiet("s2", 1500);
        pl_q.push_back(8'haa); exp_frame();
        pl_q.push_back(8'hbb); exp_frame();
        pl_q.push_back(8'hcc); exp_frame();
        pl_q.push_back(8'hdd); exp_frame();
        check_log("s2");
        chk("s2_ngrants", 32'(grant_log.size()), 32'd4);
        chk("s2_grant0", 32'(grant_log[0]), 32'd0);
        chk("s2_grant1", 32'(grant_log[1]), 32'd1);
        chk("s2_grant2", 32'(grant_log[2]), 32'd2);
        chk("s2_grant3", 32'(grant_log[3]), 32'd0);
        chk("s2_b2b_gap", 32'(send_cyc[FLEN1] - done_cyc[FLEN1-1]), 32'd3);

        // truncation at MAX_LEN, remainder becomes a new frame
        clear_logs();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b0);
        push(1, 8'h14, 1'b0); push(1, 8'h15, 1'b0); push(1, 8'h16, 1'b1);
        wait_quiet("s3", 2000);
        pl_q.push_back(8'h11); pl_q.push_back(8'h12); pl_q.push_back(8'h13); pl_q.push_back(8'h14);
        exp_frame();
        pl_q.push_back(8'h15); pl_q.push_back(8'h16); exp_frame();
        check_log("s3");
        chk("s3_trunc_cnt", 32'(trunc_cnt), 32'd1);
        chk("s3_ngrants", 32'(grant_log.size()), 32'd2);
        chk("s3_grant1", 32'(grant_log[1]), 32'd1);

        // last byte exactly at MAX_LEN is not a truncation
        clear_logs();
        push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b0); push(3, 8'h73, 1'b0); push(3, 8'h74, 1'b1);
        wait_quiet("s3b", 1500);
        pl_q.push_back(8'h71); pl_q.push_back(8'h72); pl_q.push_back(8'h73); pl_q.push_back(8'h74);
        exp_frame();
        check_log("s3b");
        chk("s3b_trunc_cnt", 32'(trunc_cnt), 32'd1);

        // owner stalls mid-frame for 50 cycles
        clear_logs();
        push(2, 8'h41, 1'b0);
        n = 0;
        while (rq[2].size() > 0 && n < 200) begin tick(); n++; end
        chk("s4_first_taken", 32'(rq[2].size()), 32'd0);
        repeat (10) tick();
        n0  = tx_log.size();
        bad = 0;
        repeat (50) begin
            tick();
            if (req_ready != 4'b0100) bad++;
        end
        chk("s4_no_send", 32'(tx_log.size()), 32'(n0));
        chk("s4_ready_held", 32'(bad), 32'd0);
        push(2, 8'h42, 1'b0);
        push(2, 8'h43, 1'b1);
        wait_quiet("s4", 800);
        pl_q.push_back(8'h41); pl_q.push_back(8'h42); pl_q.push_back(8'h43); exp_frame();
        check_log("s4");

        // reset during P_WAIT, then a fresh frame
        clear_logs();
        push(3, 8'h51, 1'b0);
        push(3, 8'h52, 1'b1);
        n = 0;
        while (tx_log.size() < 2 && n < 200) begin tick(); n++; end
        chk("s5_reach_pwait", 32'(tx_log.size()), 32'd2);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("s5");
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        tick();
        reset_n = 1'b1;
        tick();
        clear_logs();
        push(1, 8'h61, 1'b1);
        wait_quiet("s5", 400);
        pl_q.push_back(8'h61); exp_frame();
        check_log("s5");
        chk("s5_grant", 32'(grant_log[0]), 32'd1);

        chk("proto_viol", 32'(proto_viol), 32'd0);
        chk("ready_viol", 32'(ready_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
